// File: rtl/test_pattern_sequencer_if.sv
// Host/test-logic bundle for the pattern sequencer: run control and config
// from the command decoder, stimulus out to the test logic, and its result back.
interface test_pattern_sequencer_if #(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic [7:0]         loops;
    logic               out_fb;
    logic               ain;
    logic               bin;
    logic               cin;
    logic               busy;
    logic               done;
    logic [7:0]         step;
    logic [7:0]         err_cnt;

    // Host side: issues commands and closes the loop through the test logic.
    modport master (
        output start, stop, mode, dwell, loops, out_fb,
        input  ain, bin, cin, busy, done, step, err_cnt
    );

    // Sequencer side.
    modport slave (
        input  start, stop, mode, dwell, loops, out_fb,
        output ain, bin, cin, busy, done, step, err_cnt
    );
endinterface

// File: rtl/test_pattern_sequencer.sv
// Test pattern sequencer: drives {cin,bin,ain} through one of four pattern
// families, holds each pattern for a programmable dwell, and checks the
// returned out_fb against (a & b) | c on the last dwell cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs low; err_cnt/step hold
// S_DRIVE | run in progress; pattern registered on ain/bin/cin
// S_DONE  | one-cycle completion pulse; outputs low, then back to idle
module test_pattern_sequencer #(
    parameter int          DWELL_W   = 16,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    test_pattern_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_mode;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [7:0]         r_loops;
    logic [7:0]         r_step;
    logic [7:0]         r_pass;
    logic [7:0]         r_lfsr;
    logic [7:0]         r_err_cnt;
    logic [2:0]         r_pat;

    logic               w_accept;
    logic               w_tc;
    logic               w_expect;
    logic               w_mismatch;
    logic               w_pass_end;
    logic               w_run_end;
    logic [7:0]         w_step_nxt;
    logic [7:0]         w_pass_nxt;
    logic [7:0]         w_lfsr_nxt;
    logic [7:0]         w_lfsr_shift;

    // Pattern for a given step; the LFSR family uses the low bits of the
    // register value that belongs to that step.
    function automatic logic [2:0] f_pattern(input logic [1:0] m,
                                             input logic [7:0] s,
                                             input logic [7:0] l);
        logic [2:0] p;
        p = 3'b000;
        case (m)
            2'd0:    p = s[2:0];
            2'd1:    p = (s == 8'd0) ? 3'b001 : ((s == 8'd1) ? 3'b010 : 3'b100);
            2'd2:    p = l[2:0];
            default: p = {3{s[0]}};
        endcase
        return p;
    endfunction

    // Number of steps in one pass for each family.
    function automatic logic [7:0] f_pass_len(input logic [1:0] m);
        logic [7:0] n;
        n = 8'd8;
        case (m)
            2'd0:    n = 8'd8;
            2'd1:    n = 8'd3;
            2'd2:    n = 8'd255;
            default: n = 8'd2;
        endcase
        return n;
    endfunction

    // Fibonacci x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3 into bit 0.
    assign w_lfsr_shift = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the step/pass/check terms used on a dwell terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_tc        = (r_dwell_cnt == '0);
        w_expect    = (r_pat[0] & r_pat[1]) | r_pat[2];
        w_mismatch  = (bus.out_fb != w_expect);
        w_pass_end  = (r_step == (f_pass_len(r_mode) - 8'd1));
        w_step_nxt  = w_pass_end ? 8'd0 : (r_step + 8'd1);
        w_pass_nxt  = w_pass_end ? (r_pass + 8'd1) : r_pass;
        w_run_end   = w_pass_end && (r_loops != 8'd0) && (w_pass_nxt == r_loops);
        w_lfsr_nxt  = (r_mode == 2'd2) ? w_lfsr_shift : r_lfsr;

        case (r_state)
            S_IDLE: begin
                // stop beats a simultaneous start
                if (bus.start && !bus.stop) begin
                    w_state_nxt = S_DRIVE;
                    w_accept    = 1'b1;
                end
            end
            S_DRIVE: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tc && w_run_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Run datapath: config latch, dwell down-counter, step/pass, LFSR, checker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= 2'd0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_loops     <= 8'd0;
            r_step      <= 8'd0;
            r_pass      <= 8'd0;
            r_lfsr      <= LFSR_SEED;
            r_err_cnt   <= 8'd0;
            r_pat       <= 3'b000;
        end else if (w_accept) begin
            r_mode      <= bus.mode;
            r_dwell     <= bus.dwell;
            r_dwell_cnt <= bus.dwell;
            r_loops     <= bus.loops;
            r_step      <= 8'd0;
            r_pass      <= 8'd0;
            r_lfsr      <= LFSR_SEED;
            r_err_cnt   <= 8'd0;
            r_pat       <= f_pattern(bus.mode, 8'd0, LFSR_SEED);
        end else if (r_state == S_DRIVE) begin
            if (bus.stop) begin
                // abort: drop stimulus, keep step and err_cnt for inspection
                r_pat <= 3'b000;
            end else if (w_tc) begin
                if (w_mismatch && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
                r_step      <= w_step_nxt;
                r_pass      <= w_pass_nxt;
                r_lfsr      <= w_lfsr_nxt;
                r_dwell_cnt <= r_dwell;
                r_pat       <= w_run_end ? 3'b000 : f_pattern(r_mode, w_step_nxt, w_lfsr_nxt);
            end else begin
                r_dwell_cnt <= r_dwell_cnt - 1'b1;
            end
        end else begin
            r_pat <= 3'b000;
        end
    end

    assign bus.ain     = r_pat[0];
    assign bus.bin     = r_pat[1];
    assign bus.cin     = r_pat[2];
    assign bus.busy    = (r_state == S_DRIVE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.step    = r_step;
    assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Directed bench for test_pattern_sequencer. out_fb is looped back through an
// ideal (a&b)|c model or forced to a constant to create known mismatches.
module tb_test_pattern_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] fb_sel;     // 0: ideal logic, 1: forced 0, 2: forced 1
    logic [2:0] pat;
    int         n_tests;
    int         n_fail;

    test_pattern_sequencer_if #(.DWELL_W(16)) ifc ();

    test_pattern_sequencer #(
        .DWELL_W   (16),
        .LFSR_SEED (8'hA5)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    assign pat        = {ifc.cin, ifc.bin, ifc.ain};
    assign ifc.out_fb = (fb_sel == 2'd0) ? ((ifc.ain & ifc.bin) | ifc.cin) : (fb_sel == 2'd2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present config with start for one edge, then scramble config to show it is latched.
    task automatic run_start(input logic [1:0] m, input logic [15:0] d, input logic [7:0] l);
        ifc.mode  = m;
        ifc.dwell = d;
        ifc.loops = l;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.mode  = ~m;
        ifc.dwell = 16'd7;
        ifc.loops = 8'd9;
    endtask

    initial begin
        logic [7:0] lfsr_m;
        int         exp_err;
        int         n_done;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        fb_sel    = 2'd0;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        ifc.mode  = 2'd0;
        ifc.dwell = 16'd0;
        ifc.loops = 8'd0;

        // reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_done", 32'(ifc.done), 0);
        chk("rst_pat",  32'(pat), 0);
        chk("rst_step", 32'(ifc.step), 0);
        chk("rst_err",  32'(ifc.err_cnt), 0);
        tick();
        rst = 1'b0;
        tick();

        // mode 0, dwell 0, one pass, ideal feedback
        run_start(2'd0, 16'd0, 8'd1);
        for (int i = 0; i < 8; i++) begin
            chk("m0_pat",  32'(pat), i);
            chk("m0_busy", 32'(ifc.busy), 1);
            chk("m0_step", 32'(ifc.step), i);
            tick();
        end
        chk("m0_done",      32'(ifc.done), 1);
        chk("m0_done_busy", 32'(ifc.busy), 0);
        chk("m0_done_pat",  32'(pat), 0);
        tick();
        chk("m0_done_clr",  32'(ifc.done), 0);
        chk("m0_err",       32'(ifc.err_cnt), 0);
        chk("m0_step_end",  32'(ifc.step), 0);

        // mode 1, dwell 3, two passes, out_fb forced low: only 100 mismatches
        fb_sel = 2'd1;
        run_start(2'd1, 16'd3, 8'd2);
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 3; s++) begin
                for (int k = 0; k < 4; k++) begin
                    chk("m1_pat",  32'(pat), 1 << s);
                    chk("m1_step", 32'(ifc.step), s);
                    tick();
                end
            end
        end
        chk("m1_done", 32'(ifc.done), 1);
        chk("m1_err",  32'(ifc.err_cnt), 2);
        tick();

        // mode 2, dwell 0, one pass of 255 LFSR steps
        fb_sel = 2'd0;
        run_start(2'd2, 16'd0, 8'd1);
        lfsr_m = 8'hA5;
        for (int i = 0; i < 255; i++) begin
            chk("m2_pat", 32'(pat), 32'(lfsr_m[2:0]));
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            tick();
        end
        chk("m2_done", 32'(ifc.done), 1);
        chk("m2_err",  32'(ifc.err_cnt), 0);
        tick();

        // mode 3, loops 0, out_fb forced high: 000 steps mismatch, saturate, then stop
        fb_sel = 2'd2;
        run_start(2'd3, 16'd0, 8'd0);
        for (int s = 0; s <= 600; s++) begin
            exp_err = (s + 1) / 2;
            if (exp_err > 255) exp_err = 255;
            chk("m3_pat", 32'(pat), s[0] ? 7 : 0);
            chk("m3_err", 32'(ifc.err_cnt), exp_err);
            tick();
        end
        chk("m3_pat_pre_stop",  32'(pat), 7);
        chk("m3_step_pre_stop", 32'(ifc.step), 1);
        chk("m3_busy_pre_stop", 32'(ifc.busy), 1);
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
        chk("stop_busy", 32'(ifc.busy), 0);
        chk("stop_pat",  32'(pat), 0);
        chk("stop_step", 32'(ifc.step), 1);
        chk("stop_err",  32'(ifc.err_cnt), 255);
        for (int i = 0; i < 3; i++) begin
            chk("stop_no_done", 32'(ifc.done), 0);
            chk("stop_idle",    32'(ifc.busy), 0);
            tick();
        end

        // start and stop together in idle: no run
        fb_sel    = 2'd0;
        ifc.mode  = 2'd0;
        ifc.dwell = 16'd0;
        ifc.loops = 8'd1;
        ifc.start = 1'b1;
        ifc.stop  = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ss_busy", 32'(ifc.busy), 0);
            chk("ss_pat",  32'(pat), 0);
            tick();
        end

        // start during busy with other config is ignored
        run_start(2'd0, 16'd0, 8'd1);
        for (int i = 0; i < 8; i++) begin
            chk("rb_pat", 32'(pat), i);
            if (i == 2) begin
                ifc.mode  = 2'd3;
                ifc.dwell = 16'd5;
                ifc.loops = 8'd0;
                ifc.start = 1'b1;
            end else begin
                ifc.start = 1'b0;
            end
            tick();
        end
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifc.done === 1'b1) n_done++;
            tick();
        end
        chk("rb_done_cnt", 32'(n_done), 1);
        chk("rb_busy_end", 32'(ifc.busy), 0);

        // async reset mid-run at mode 0 step 5 with out_fb forced high
        fb_sel = 2'd2;
        run_start(2'd0, 16'd0, 8'd1);
        repeat (5) tick();
        chk("mr_step_pre", 32'(ifc.step), 5);
        chk("mr_err_pre",  32'(ifc.err_cnt), 3);
        chk("mr_pat_pre",  32'(pat), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_pat",  32'(pat), 0);
        chk("mr_busy", 32'(ifc.busy), 0);
        chk("mr_step", 32'(ifc.step), 0);
        chk("mr_err",  32'(ifc.err_cnt), 0);
        chk("mr_done", 32'(ifc.done), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mr_no_done", 32'(ifc.done), 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
